// File: rtl/btn_debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
// Imported by the per-channel engine and the top wrapper.
package btn_debounce_pkg;

  // 10 ms at 27 MHz, and the narrowest counter that holds it
  localparam int unsigned DEB_CYCLES_27MHZ = 270000;
  localparam int unsigned DEB_CNT_W_27MHZ  = 19;

  typedef enum logic [1:0] {
    REL     = 2'd0,
    REL_CHK = 2'd1,
    PRS     = 2'd2,
    PRS_CHK = 2'd3
  } btn_state_e;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
  } btn_out_t;

  // True when the state means "button accepted as pressed"
  function automatic logic st_pressed(input btn_state_e st);
    return (st == PRS) || (st == PRS_CHK);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability FSM,
// run-length counter and registered level/press/release outputs.
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEB_CYCLES_27MHZ,
  parameter int unsigned CNT_W           = DEB_CNT_W_27MHZ
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     pin_act,
  output btn_out_t out
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

  logic [1:0]       sync_q, sync_d;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  btn_out_t         out_q, out_d;
  logic             s;

  // Synchroniser shifts the already polarity-normalised pin in
  always_comb begin
    sync_d = {sync_q[0], pin_act};
  end

  assign s = sync_q[1];

  // Stability FSM: a change is accepted only after an unbroken run
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      REL: begin
        if (s) begin
          if (SINGLE) begin
            state_d = PRS;
            cnt_d   = '0;
          end else begin
            state_d = REL_CHK;
            cnt_d   = ONE;
          end
        end
      end
      REL_CHK: begin
        if (!s) begin
          state_d = REL;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = PRS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      PRS: begin
        if (!s) begin
          if (SINGLE) begin
            state_d = REL;
            cnt_d   = '0;
          end else begin
            state_d = PRS_CHK;
            cnt_d   = ONE;
          end
        end
      end
      PRS_CHK: begin
        if (s) begin
          state_d = PRS;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = REL;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register: level follows state, pulses mark its edges
  always_comb begin
    out_d       = '0;
    out_d.level = st_pressed(state_q);
    out_d.press = out_d.level & ~out_q.level;
    out_d.rel   = ~out_d.level & out_q.level;
  end

  // Sync flops reset to 0 here, i.e. the inactive pin level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // FSM state and run counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button front end: normalises pin polarity and packs the
// per-channel debounce engines onto level/press/release buses.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int unsigned N_BTN           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEB_CYCLES_27MHZ,
  parameter int unsigned CNT_W           = DEB_CNT_W_27MHZ,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam logic [N_BTN-1:0] POL =
    ACTIVE_LOW ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

  logic [N_BTN-1:0] pin_act;
  btn_out_t         ch_out [N_BTN];

  // 1 = pressed from here on; the inversion commutes with the
  // synchroniser, so its 0 reset equals the inactive pin level
  always_comb begin
    pin_act = btn_raw ^ POL;
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .pin_act (pin_act[i]),
      .out     (ch_out[i])
    );
  end

  // Pack per-channel bundles onto the output buses
  always_comb begin
    btn_level   = '0;
    btn_press   = '0;
    btn_release = '0;
    for (int i = 0; i < N_BTN; i++) begin
      btn_level[i]   = ch_out[i].level;
      btn_press[i]   = ch_out[i].press;
      btn_release[i] = ch_out[i].rel;
    end
  end

endmodule
